mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: address and data width.
REQ-002 Parameter WDOG_CYCLES, default 255: watchdog limit in cycles; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 ireq  input  1  fetch request; the requester holds it until iready.
REQ-006 iaddr  input  WIDTH  fetch address.
REQ-007 irdata  output  WIDTH  fetched word, registered.
REQ-008 iready  output  1  one-cycle pulse; irdata valid.
REQ-009 dreq  input  1  data request; the requester holds it until dready.
REQ-010 dwe  input  1  data write enable; qualifies dreq.
REQ-011 daddr  input  WIDTH  data address.
REQ-012 dwdata  input  WIDTH  store data.
REQ-013 drdata  output  WIDTH  load data, registered.
REQ-014 dready  output  1  one-cycle pulse; data access complete.
REQ-015 mreq  output  1  memory request; held until mack.
REQ-016 mwe  output  1  memory write enable.
REQ-017 maddr  output  WIDTH  memory address, registered.
REQ-018 mwdata  output  WIDTH  memory write data, registered.
REQ-019 mrdata  input  WIDTH  memory read data; valid with mack.
REQ-020 mack  input  1  memory acknowledge; a single-cycle pulse per transaction.
REQ-021 merr  output  1  sticky watchdog error flag.

Function
REQ-022 The arbiter SHALL implement FSM states IDLE, IBUSY, DBUSY and ERR (ERR exists only when the macro in REQ-037 is defined).
REQ-023 In IDLE, if dreq is 1 it SHALL latch daddr, dwdata and dwe into maddr, mwdata and mwe, and enter DBUSY; otherwise, if ireq is 1, it SHALL latch iaddr (mwe = 0) and enter IBUSY. Data always has priority.
REQ-024 mreq SHALL be 1 in every IBUSY and DBUSY cycle and 0 in all other states.
REQ-025 In xBUSY with mack = 1, the arbiter SHALL register mrdata into irdata or drdata (loads only), pulse iready or dready high for exactly the next cycle, and return to IDLE.
REQ-026 On a data write, drdata SHALL hold its previous value, and dready SHALL still pulse.
REQ-027 Minimum latency SHALL be 2 cycles: req at cycle 0, mreq at cycle 1, mack at cycle 1, ready at cycle 2.
REQ-028 In the cycle iready (or dready) is 1, IDLE SHALL ignore ireq (or dreq), because it is a stale hold. The other requester SHALL remain eligible in that cycle.
REQ-029 maddr, mwdata and mwe SHALL remain stable while mreq is 1.
REQ-030 A mack received in IDLE or ERR SHALL be ignored.
REQ-031 Outputs irdata and drdata SHALL hold their values between ready pulses.

Reset
REQ-032 While reset = 0 at a clock edge, the FSM SHALL go to IDLE. All outputs SHALL then be 0: mreq, mwe, maddr, mwdata, irdata, drdata, iready, dready and merr.
REQ-033 A reset asserted during IBUSY or DBUSY SHALL abandon the transaction: mreq goes to 0 on the next edge, no ready pulse is issued, and a later mack is ignored.
REQ-034 The watchdog counter SHALL be cleared by reset.

Configuration
REQ-035 With MEM_ARB_WDOG_EN defined, a counter SHALL count cycles spent in IBUSY or DBUSY. The counter SHALL clear on every entry to a BUSY state.
REQ-036 With MEM_ARB_WDOG_EN defined, if the count reaches WDOG_CYCLES without a mack, the FSM SHALL enter ERR, drop mreq and set merr. ERR SHALL persist until reset, issue no ready pulses, and ignore all requests.
REQ-037 Without MEM_ARB_WDOG_EN, the block SHALL contain no counter and no ERR state, merr SHALL be tied to 0, and BUSY SHALL wait for mack indefinitely.
REQ-038 A mack arriving in the same cycle as the count reaching WDOG_CYCLES SHALL win, and the transaction SHALL complete normally.

Structure
REQ-039 Package mem_arb_pkg SHALL hold the state enum typedef (arb_state_t) and the constant WDOG_W = 16.
REQ-040 The watchdog SHALL be a single sub-module, mem_arb_wdog, instantiated only under MEM_ARB_WDOG_EN.

Verification
REQ-041 Single fetch: ireq with iaddr=0x00000040, mack one cycle after mreq with mrdata=0x8C080004 -> iready pulse with irdata=0x8C080004; total latency 3 cycles.
REQ-042 Conflict: ireq and dreq rise together (daddr=0x100, dwe=0) -> the data transaction is issued first with maddr=0x100; the fetch follows immediately after dready, and ireq is held throughout.
REQ-043 Store: dreq, dwe=1, daddr=0x200, dwdata=0xDEADBEEF -> mwe=1 and mwdata=0xDEADBEEF stable until mack; dready pulses; drdata is unchanged.
REQ-044 Stale hold: after iready, ireq is held one extra cycle -> no second mreq is issued.
REQ-045 Reset mid-operation: reset=0 during DBUSY, then mack arrives -> mreq=0 on the next edge, no dready, and the stray mack is ignored.
REQ-046 Watchdog (MEM_ARB_WDOG_EN, WDOG_CYCLES=4): mack withheld -> merr=1 after 4 BUSY cycles and mreq drops. Repeat with mack in the 4th cycle -> normal completion and merr=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Purpose: shared state encoding, watchdog width and helpers for mem_arbiter.
// Latency: none (types and constants only).
// Backpressure: none. The ERR state exists only when MEM_ARB_WDOG_EN is defined.
package mem_arb_pkg;

  // Width of the watchdog cycle counter; covers the full 1..65535 limit range.
  localparam int WDOG_W = 16;

  // Arbiter FSM states. ERR is only reachable through the watchdog.
`ifdef MEM_ARB_WDOG_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    ERR   = 2'd3
  } arb_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;
`endif

  // True while a memory transaction is outstanding.
  function automatic logic is_busy(input arb_state_t s);
    return (s == IBUSY) || (s == DBUSY);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Purpose: bundles fetch port, data port and memory port of the arbiter.
// Latency: none (wires only).
// Backpressure: req/ready handshakes on both requester ports, req/ack on memory.
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  // Fetch port
  logic             ireq;
  logic [WIDTH-1:0] iaddr;
  logic [WIDTH-1:0] irdata;
  logic             iready;
  // Data port
  logic             dreq;
  logic             dwe;
  logic [WIDTH-1:0] daddr;
  logic [WIDTH-1:0] dwdata;
  logic [WIDTH-1:0] drdata;
  logic             dready;
  // Memory port
  logic             mreq;
  logic             mwe;
  logic [WIDTH-1:0] maddr;
  logic [WIDTH-1:0] mwdata;
  logic [WIDTH-1:0] mrdata;
  logic             mack;
  // Status
  logic             merr;

  // Arbiter side
  modport slave (
    input  ireq, iaddr, dreq, dwe, daddr, dwdata, mrdata, mack,
    output irdata, iready, drdata, dready, mreq, mwe, maddr, mwdata, merr
  );

  // Requesters plus memory side
  modport master (
    output ireq, iaddr, dreq, dwe, daddr, dwdata, mrdata, mack,
    input  irdata, iready, drdata, dready, mreq, mwe, maddr, mwdata, merr
  );

endinterface

// File: rtl/mem_arb_wdog.sv
// Purpose: counts cycles of an outstanding memory transaction, flags expiry.
// Latency: o_expire is combinational from the registered count (same cycle).
// Backpressure: none; restarts from zero whenever a new transaction is launched.
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int WDOG_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_busy,
  output logic o_expire
);

  // Count value seen during the last permitted BUSY cycle.
  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] r_cnt;

  // Cleared on the edge that enters BUSY, so the first BUSY cycle sees zero;
  // saturates at LIMIT so a late mack never lets the count wrap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_busy && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry is raised in the WDOG_CYCLES-th BUSY cycle; the FSM lets mack win.
  assign o_expire = i_busy && (r_cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates fetch and data requesters onto one memory port, data first.
// Latency: 2 cycles minimum (req -> mreq next cycle -> ready the cycle after mack).
// Backpressure: requesters hold req until ready; mreq held until mack. Optional watchdog: MEM_ARB_WDOG_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int WDOG_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  arb_state_t       r_state;
  logic             r_mreq;
  logic             r_mwe;
  logic [WIDTH-1:0] r_maddr;
  logic [WIDTH-1:0] r_mwdata;
  logic [WIDTH-1:0] r_irdata;
  logic [WIDTH-1:0] r_drdata;
  logic             r_iready;
  logic             r_dready;

  // A requester still holding req in its own ready cycle is a stale hold.
  logic w_dsel;
  logic w_isel;

  assign w_dsel = bus.dreq && !r_dready;
  assign w_isel = bus.ireq && !r_iready;

`ifdef MEM_ARB_WDOG_EN
  logic r_merr;
  logic w_start;
  logic w_busy;
  logic w_expire;

  assign w_busy  = is_busy(r_state);
  assign w_start = (r_state == IDLE) && (w_dsel || w_isel);

  mem_arb_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_start),
    .i_busy  (w_busy),
    .o_expire(w_expire)
  );

  assign bus.merr = r_merr;
`else
  assign bus.merr = 1'b0;
`endif

  // Flag an out-of-range watchdog limit in simulation.
  always_comb begin
    assert ((WDOG_CYCLES >= 1) && (WDOG_CYCLES <= 65535))
      else $error("mem_arbiter: WDOG_CYCLES out of range 1..65535");
  end

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_mreq   <= 1'b0;
      r_mwe    <= 1'b0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
      r_iready <= 1'b0;
      r_dready <= 1'b0;
`ifdef MEM_ARB_WDOG_EN
      r_merr   <= 1'b0;
`endif
    end else begin
      // Ready outputs are single-cycle pulses.
      r_iready <= 1'b0;
      r_dready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_dsel) begin
            r_maddr  <= bus.daddr;
            r_mwdata <= bus.dwdata;
            r_mwe    <= bus.dwe;
            r_mreq   <= 1'b1;
            r_state  <= DBUSY;
          end else if (w_isel) begin
            r_maddr  <= bus.iaddr;
            r_mwe    <= 1'b0;
            r_mreq   <= 1'b1;
            r_state  <= IBUSY;
          end
        end
        IBUSY: begin
          if (bus.mack) begin
            r_irdata <= bus.mrdata;
            r_iready <= 1'b1;
            r_mreq   <= 1'b0;
            r_state  <= IDLE;
          end
`ifdef MEM_ARB_WDOG_EN
          else if (w_expire) begin
            r_mreq  <= 1'b0;
            r_merr  <= 1'b1;
            r_state <= ERR;
          end
`endif
        end
        DBUSY: begin
          if (bus.mack) begin
            // Stores leave drdata untouched.
            if (!r_mwe) begin
              r_drdata <= bus.mrdata;
            end
            r_dready <= 1'b1;
            r_mreq   <= 1'b0;
            r_state  <= IDLE;
          end
`ifdef MEM_ARB_WDOG_EN
          else if (w_expire) begin
            r_mreq  <= 1'b0;
            r_merr  <= 1'b1;
            r_state <= ERR;
          end
`endif
        end
`ifdef MEM_ARB_WDOG_EN
        ERR: begin
          // Dead until reset: no requests, no acks, no ready pulses.
          r_state <= ERR;
        end
`endif
        default: begin
          r_mreq  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mreq   = r_mreq;
  assign bus.mwe    = r_mwe;
  assign bus.maddr  = r_maddr;
  assign bus.mwdata = r_mwdata;
  assign bus.irdata = r_irdata;
  assign bus.drdata = r_drdata;
  assign bus.iready = r_iready;
  assign bus.dready = r_dready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed self-checking bench for mem_arbiter with a transaction-level model.
// Latency: model predicts outputs cycle by cycle; literals pin the key cases.
// Backpressure: bench plays both requesters and the memory (mack driven by hand).
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int WD = 4;
`ifdef MEM_ARB_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  mem_arbiter_if #(.WIDTH(W)) bus ();

  mem_arbiter #(
    .WIDTH(W),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the memory, what was latched, what must be shown.
  int          m_owner = 0;   // 0 none, 1 fetch, 2 data
  int          m_busy  = 0;   // BUSY cycles elapsed in current transaction
  logic        m_mreq = 1'b0, m_mwe = 1'b0, m_iready = 1'b0, m_dready = 1'b0, m_merr = 1'b0;
  logic [31:0] m_maddr = '0, m_mwdata = '0, m_irdata = '0, m_drdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    logic was_i, was_d;
    if (!rst_n) begin
      m_owner = 0; m_busy = 0;
      m_mreq = 0; m_mwe = 0; m_iready = 0; m_dready = 0; m_merr = 0;
      m_maddr = '0; m_mwdata = '0; m_irdata = '0; m_drdata = '0;
    end else begin
      was_i = m_iready;
      was_d = m_dready;
      m_iready = 0;
      m_dready = 0;
      if (m_merr) begin
        m_owner = 0;
      end else if (m_owner == 0) begin
        if (bus.dreq && !was_d) begin
          m_owner = 2; m_busy = 0;
          m_maddr = bus.daddr; m_mwdata = bus.dwdata; m_mwe = bus.dwe;
        end else if (bus.ireq && !was_i) begin
          m_owner = 1; m_busy = 0;
          m_maddr = bus.iaddr; m_mwe = 0;
        end
      end else begin
        m_busy++;
        if (bus.mack) begin
          if (m_owner == 1) begin
            m_irdata = bus.mrdata;
            m_iready = 1;
          end else begin
            if (!m_mwe) m_drdata = bus.mrdata;
            m_dready = 1;
          end
          m_owner = 0;
        end else if (WDOG_ON && (m_busy >= WD)) begin
          m_merr  = 1;
          m_owner = 0;
        end
      end
      m_mreq = (m_owner != 0);
    end
  endtask

  // Compare every output against the model, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_mreq",   bus.mreq,   m_mreq);
      check("cyc_mwe",    bus.mwe,    m_mwe);
      check("cyc_maddr",  bus.maddr,  m_maddr);
      check("cyc_mwdata", bus.mwdata, m_mwdata);
      check("cyc_irdata", bus.irdata, m_irdata);
      check("cyc_iready", bus.iready, m_iready);
      check("cyc_drdata", bus.drdata, m_drdata);
      check("cyc_dready", bus.dready, m_dready);
      check("cyc_merr",   bus.merr,   m_merr);
    end
    model_step();
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.ireq = 0; bus.iaddr = '0;
    bus.dreq = 0; bus.dwe = 0; bus.daddr = '0; bus.dwdata = '0;
    bus.mack = 0; bus.mrdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    tick(2);
    chk_en = 1;
    check("rst_mreq",   bus.mreq,   32'h0);
    check("rst_maddr",  bus.maddr,  32'h0);
    check("rst_irdata", bus.irdata, 32'h0);
    check("rst_drdata", bus.drdata, 32'h0);
    check("rst_ready",  {bus.iready, bus.dready}, 32'h0);
    check("rst_merr",   bus.merr,   32'h0);
    rst_n = 1;
    tick();

    // Single fetch, mack one cycle after mreq: ready 3 cycles after req.
    bus.ireq = 1; bus.iaddr = 32'h0000_0040;
    tick();
    check("f_mreq",  bus.mreq,  32'h1);
    check("f_maddr", bus.maddr, 32'h0000_0040);
    check("f_mwe",   bus.mwe,   32'h0);
    tick();
    check("f_no_early_ready", bus.iready, 32'h0);
    bus.mack = 1; bus.mrdata = 32'h8C08_0004;
    tick();
    bus.mack = 0; bus.mrdata = '0;
    check("f_iready",      bus.iready, 32'h1);
    check("f_irdata",      bus.irdata, 32'h8C08_0004);
    check("f_model_irdata", m_irdata,  32'h8C08_0004);
    // ireq still held in the iready cycle: must not launch again.
    tick();
    bus.ireq = 0;
    check("stale_no_mreq",    bus.mreq,   32'h0);
    check("stale_model_mreq", m_mreq,     32'h0);
    check("f_irdata_hold",    bus.irdata, 32'h8C08_0004);

    // Conflict: data wins, fetch issued right after dready.
    tick();
    bus.ireq = 1; bus.iaddr = 32'h300;
    bus.dreq = 1; bus.daddr = 32'h100; bus.dwe = 0;
    tick();
    check("c_mreq",  bus.mreq,  32'h1);
    check("c_maddr", bus.maddr, 32'h100);
    check("c_mwe",   bus.mwe,   32'h0);
    bus.mack = 1; bus.mrdata = 32'h1111_2222;
    tick();
    bus.mack = 0;
    check("c_dready", bus.dready, 32'h1);
    check("c_drdata", bus.drdata, 32'h1111_2222);
    check("c_iready_low", bus.iready, 32'h0);
    tick();
    bus.dreq = 0;
    check("c_fetch_mreq",  bus.mreq,  32'h1);
    check("c_fetch_maddr", bus.maddr, 32'h300);
    bus.mack = 1; bus.mrdata = 32'h3333_4444;
    tick();
    bus.mack = 0; bus.ireq = 0;
    check("c_iready",      bus.iready, 32'h1);
    check("c_irdata",      bus.irdata, 32'h3333_4444);
    check("c_drdata_hold", bus.drdata, 32'h1111_2222);

    // Store: address/data/we stable while waiting, drdata untouched.
    tick();
    bus.dreq = 1; bus.dwe = 1; bus.daddr = 32'h200; bus.dwdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) begin
        bus.daddr = 32'h999; bus.dwdata = 32'h1234_5678; bus.dwe = 0;
      end
      check("s_mreq",   bus.mreq,   32'h1);
      check("s_mwe",    bus.mwe,    32'h1);
      check("s_maddr",  bus.maddr,  32'h200);
      check("s_mwdata", bus.mwdata, 32'hDEAD_BEEF);
    end
    bus.mack = 1; bus.mrdata = 32'hBADB_AD00;
    tick();
    bus.mack = 0;
    check("s_dready", bus.dready, 32'h1);
    check("s_drdata_unchanged", bus.drdata, 32'h1111_2222);
    check("s_model_drdata",     m_drdata,   32'h1111_2222);
    tick();
    bus.dreq = 0; bus.dwe = 0;
    check("s_stale_no_mreq", bus.mreq, 32'h0);

    // Stray mack while idle is ignored.
    bus.mack = 1; bus.mrdata = 32'hFFFF_FFFF;
    tick();
    bus.mack = 0;
    check("idle_mack_no_ready", {bus.iready, bus.dready}, 32'h0);
    check("idle_mack_irdata",   bus.irdata, 32'h3333_4444);

    // Reset during DBUSY abandons the load; later mack is stray.
    bus.dreq = 1; bus.dwe = 0; bus.daddr = 32'h180;
    tick();
    check("r_mreq_busy", bus.mreq, 32'h1);
    rst_n = 0;
    tick();
    check("r_mreq_drop", bus.mreq,   32'h0);
    check("r_drdata",    bus.drdata, 32'h0);
    check("r_irdata",    bus.irdata, 32'h0);
    rst_n = 1; bus.dreq = 0; bus.mack = 1; bus.mrdata = 32'hCAFE_F00D;
    tick();
    bus.mack = 0;
    check("r_stray_no_dready", bus.dready, 32'h0);
    check("r_stray_mreq",      bus.mreq,   32'h0);
    check("r_stray_drdata",    bus.drdata, 32'h0);
    tick();

`ifdef MEM_ARB_WDOG_EN
    // Watchdog: mack withheld for WD BUSY cycles -> ERR.
    bus.ireq = 1; bus.iaddr = 32'h500;
    for (int k = 1; k <= WD; k++) begin
      tick();
      check("w_busy_mreq", bus.mreq, 32'h1);
      check("w_busy_merr", bus.merr, 32'h0);
    end
    tick();
    check("w_merr",      bus.merr,   32'h1);
    check("w_mreq_drop", bus.mreq,   32'h0);
    check("w_model_merr", m_merr,    32'h1);
    bus.dreq = 1; bus.mack = 1; bus.mrdata = 32'h7777_7777;
    tick(2);
    bus.mack = 0;
    check("w_err_sticky", bus.merr, 32'h1);
    check("w_err_no_req", bus.mreq, 32'h0);
    check("w_err_no_ready", {bus.iready, bus.dready}, 32'h0);
    bus.ireq = 0; bus.dreq = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    check("w_rst_merr", bus.merr, 32'h0);
    // mack in the last permitted cycle wins.
    bus.ireq = 1; bus.iaddr = 32'h504;
    for (int k = 1; k < WD; k++) begin
      tick();
      check("w2_mreq", bus.mreq, 32'h1);
    end
    tick();
    bus.mack = 1; bus.mrdata = 32'h0BAD_F00D;
    tick();
    bus.mack = 0; bus.ireq = 0;
    check("w2_iready", bus.iready, 32'h1);
    check("w2_irdata", bus.irdata, 32'h0BAD_F00D);
    check("w2_merr",   bus.merr,   32'h0);
`else
    // No watchdog: BUSY waits for mack indefinitely.
    bus.ireq = 1; bus.iaddr = 32'h500;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("nw_mreq", bus.mreq, 32'h1);
      check("nw_merr", bus.merr, 32'h0);
    end
    bus.mack = 1; bus.mrdata = 32'h0BAD_F00D;
    tick();
    bus.mack = 0; bus.ireq = 0;
    check("nw_iready", bus.iready, 32'h1);
    check("nw_irdata", bus.irdata, 32'h0BAD_F00D);
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
